// File: rtl/uart_fifo_bridge.sv
// CPU-side TX/RX byte FIFOs in front of the UART register interface.
// The bridge is the only UART bus master: it polls status, feeds TX bytes and collects and acknowledges RX bytes.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cs,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_dbw,
  output logic [7:0] cpu_dbr,
  output logic       irq,
  input  logic [7:0] u_dbr,
  output logic [7:0] u_dbw,
  output logic       u_addr,
  output logic       u_we
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    POLL  = 3'd0,
    EVAL  = 3'd1,
    TXWR  = 3'd2,
    RXRD  = 3'd3,
    RXCAP = 3'd4
  } state_t;

  state_t state;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_ovf, tx_ie, rx_ie;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic cpu_wr0, cpu_rd0, cpu_wr1;
  logic tx_push, tx_pop, tx_ovf_set;
  logic rx_req, rx_push, rx_pop, rx_ovf_set;
  logic ovf_clr;

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign cpu_wr0 = cpu_cs &&  cpu_we && (cpu_addr == 2'd0);
  assign cpu_rd0 = cpu_cs && !cpu_we && (cpu_addr == 2'd0);
  assign cpu_wr1 = cpu_cs &&  cpu_we && (cpu_addr == 2'd1);
  assign ovf_clr = cpu_wr1 && cpu_dbw[0];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign tx_pop     = (state == TXWR) && !tx_empty;
  assign tx_push    = cpu_wr0 && (!tx_full || tx_pop);
  assign tx_ovf_set = cpu_wr0 && tx_full && !tx_pop;

  assign rx_req     = (state == RXCAP);
  assign rx_pop     = cpu_rd0 && !rx_empty;
  assign rx_push    = rx_req && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_req && rx_full && !rx_pop;

  // UART bus signals are a pure decode of the master state.
  assign u_we   = (state == TXWR) || (state == RXCAP);
  assign u_addr = !((state == TXWR) || (state == RXRD));
  assign u_dbw  = tx_mem[tx_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) tx_mem[i] <= 8'h00;
    end else if (tx_push) begin
      tx_mem[tx_wp] <= cpu_dbw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) rx_mem[i] <= 8'h00;
    end else if (rx_push) begin
      rx_mem[rx_wp] <= u_dbr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky overflow flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      tx_ie  <= 1'b0;
      rx_ie  <= 1'b0;
    end else begin
      if (tx_ovf_set)   tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
      if (rx_ovf_set)   rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
      if (cpu_wr1) begin
        rx_ie <= cpu_dbw[1];
        tx_ie <= cpu_dbw[2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_dbr <= 8'h00;
    end else if (cpu_cs && !cpu_we) begin
      case (cpu_addr)
        2'd0:    cpu_dbr <= rx_empty ? 8'h00 : rx_mem[rx_rp];
        2'd1:    cpu_dbr <= {tx_full, tx_empty, rx_full, rx_empty,
                             tx_ovf, rx_ovf, tx_ie, rx_ie};
        2'd2:    cpu_dbr <= 8'(tx_cnt);
        default: cpu_dbr <= 8'(rx_cnt);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (rx_ie && !rx_empty) || (tx_ie && tx_empty);
  end

  // UART master: status in EVAL is the value sampled during POLL; RX wins over TX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= POLL;
    end else begin
      case (state)
        POLL:    state <= EVAL;
        EVAL: begin
          if (u_dbr[6])                      state <= RXRD;
          else if (!u_dbr[7] && !tx_empty)   state <= TXWR;
          else                               state <= POLL;
        end
        TXWR:    state <= POLL;
        RXRD:    state <= RXCAP;
        RXCAP:   state <= POLL;
        default: state <= POLL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: behavioural UART register model plus scoreboards
// for UART writes and CPU reads, driven by directed vectors.
module tb_uart_fifo_bridge;

  localparam int unsigned DEPTH = 16;
  localparam int RX_GAP  = 12;
  localparam int TX_BUSY = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_cs = 1'b0;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_dbw = 8'h00;
  logic [7:0] cpu_dbr;
  logic       irq;
  logic [7:0] u_dbr;
  logic [7:0] u_dbw;
  logic       u_addr;
  logic       u_we;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] rx_src[$];

  // UART model state
  logic       tx_pend;
  logic       force_busy = 1'b0;
  int         tx_busy;
  logic       rx_ok;
  logic [7:0] rx_data;
  logic [7:0] rx_next;
  int         rx_tmr;
  logic       rd_fire;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_dbw(cpu_dbw), .cpu_dbr(cpu_dbr), .irq(irq),
    .u_dbr(u_dbr), .u_dbw(u_dbw), .u_addr(u_addr), .u_we(u_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART register model: registered read data, TX busy timer, RX arrivals every RX_GAP cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_dbr   <= 8'h00;
      tx_pend <= 1'b0;
      tx_busy <= 0;
      rx_ok   <= 1'b0;
      rx_data <= 8'h00;
      rx_tmr  <= 0;
    end else begin
      u_dbr <= u_addr ? {tx_pend | force_busy, rx_ok, 6'b0} : rx_data;
      if (u_we && !u_addr) begin
        check("uart_write_while_pending", 32'(tx_pend | force_busy), 32'd0);
        tx_pend <= 1'b1;
        tx_busy <= TX_BUSY;
      end else if (tx_busy > 0) begin
        tx_busy <= tx_busy - 1;
        if (tx_busy == 1) tx_pend <= 1'b0;
      end
      if (rx_tmr == 0 && rx_src.size() > 0) begin
        check("uart_rx_overrun", 32'(rx_ok), 32'd0);
        rx_next = rx_src.pop_front();
        rx_data <= rx_next;
        rx_ok   <= 1'b1;
        rx_tmr  <= RX_GAP;
      end else begin
        if (rx_tmr > 0) rx_tmr <= rx_tmr - 1;
        if (u_we && u_addr) rx_ok <= 1'b0;
      end
    end
  end

  // TX scoreboard: every UART data write pops the next expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && u_we && !u_addr) begin
      if (tx_exp.size() == 0) begin
        check("tx_unexpected_write", 32'(u_dbw), 32'h100);
      end else begin
        e = tx_exp.pop_front();
        check("tx_byte", 32'(u_dbw), 32'(e));
      end
    end
  end

  // CPU read scoreboard: data is compared the cycle after each read access.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_fire <= 1'b0;
    else     rd_fire <= cpu_cs && !cpu_we;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && rd_fire) begin
      if (rd_exp.size() == 0) begin
        check("rd_unexpected", 32'(cpu_dbr), 32'h100);
      end else begin
        e = rd_exp.pop_front();
        check("cpu_read", 32'(cpu_dbr), 32'(e));
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dbw = d;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic [7:0] exp);
    rd_exp.push_back(exp);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    cpu_cs = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] d);
    tx_exp.push_back(d);
    cpu_wr(2'd0, d);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || rx_src.size() != 0 || rx_ok || tx_pend || rx_tmr != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_u_we", 32'(u_we), 32'd0);
    check("rst_u_addr", 32'(u_addr), 32'd1);
    check("rst_u_dbw", 32'(u_dbw), 32'h00);
    check("rst_cpu_dbr", 32'(cpu_dbr), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rd(2'd2, 8'h00);
    cpu_rd(2'd0, 8'h00);
    cpu_rd(2'd1, 8'h50);

    // Reset asserted in the middle of a UART write
    tx_send(8'hAA);
    n = 0;
    while (!(u_we && !u_addr) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_txwr", 32'(n < 20), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_u_we", 32'(u_we), 32'd0);
    check("midrst_u_addr", 32'(u_addr), 32'd1);
    check("midrst_u_dbw", 32'(u_dbw), 32'h00);
    check("midrst_cpu_dbr", 32'(cpu_dbr), 32'h00);
    check("midrst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cpu_rd(2'd1, 8'h50);
    cpu_rd(2'd2, 8'h00);

    // Three TX bytes queued while the UART is busy, then drained in order
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_send(8'h55);
    tx_send(8'hA3);
    tx_send(8'h0F);
    cpu_rd(2'd2, 8'h03);
    force_busy = 1'b0;
    wait_idle("tx_drain", 500);
    cpu_rd(2'd2, 8'h00);

    // TX overflow: 17 writes into a 16-deep FIFO, the last is dropped
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_exp.push_back(8'(8'h20 + i));
      cpu_wr(2'd0, 8'(8'h20 + i));
    end
    cpu_rd(2'd2, 8'h10);
    cpu_rd(2'd1, 8'h98);
    cpu_wr(2'd1, 8'h01);
    cpu_rd(2'd1, 8'h90);
    force_busy = 1'b0;
    wait_idle("tx_full_drain", 2000);
    cpu_rd(2'd2, 8'h00);

    // RX two bytes, then an empty read
    rx_src.push_back(8'h3C);
    rx_src.push_back(8'hC3);
    wait_idle("rx_collect", 500);
    cpu_rd(2'd3, 8'h02);
    cpu_rd(2'd0, 8'h3C);
    cpu_rd(2'd0, 8'hC3);
    cpu_rd(2'd0, 8'h00);
    cpu_rd(2'd3, 8'h00);

    // RX overflow with a TX byte competing for the UART
    for (int i = 0; i < 17; i++) rx_src.push_back(8'(8'h40 + i));
    tx_send(8'h11);
    wait_idle("rx_ovf_collect", 1500);
    cpu_rd(2'd3, 8'h10);
    cpu_rd(2'd1, 8'h64);
    for (int i = 0; i < 16; i++) cpu_rd(2'd0, 8'(8'h40 + i));
    cpu_rd(2'd3, 8'h00);
    cpu_wr(2'd1, 8'h01);
    cpu_rd(2'd1, 8'h50);

    // irq from RX with rx_ie
    cpu_wr(2'd1, 8'h02);
    repeat (2) @(negedge clk);
    check("irq_rx_idle", 32'(irq), 32'd0);
    rx_src.push_back(8'h77);
    n = 0;
    while (!(u_we && u_addr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_rxcap", 32'(n < 50), 32'd1);
    check("irq_before_push", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("irq_after_push", 32'(irq), 32'd1);
    cpu_rd(2'd0, 8'h77);
    check("irq_at_pop", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_after_pop", 32'(irq), 32'd0);

    // irq from empty TX with tx_ie
    cpu_wr(2'd1, 8'h04);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", 32'(irq), 32'd1);
    cpu_rd(2'd1, 8'h52);

    repeat (4) @(negedge clk);
    check("tx_sb_drained", 32'(tx_exp.size()), 32'd0);
    check("rd_sb_drained", 32'(rd_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
